// File: rtl/wb_commit.sv
// Writeback/commit stage: retires one instruction per cycle and drives the
// register-file write, CSR write, exception/ERTN commit and fetch redirect.
module wb_commit #(
    parameter int          DRAIN_CYCLES = 3,
    parameter logic [31:0] RESET_PC     = 32'h1c000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_exe_out,
    input  logic        wb_is_load,
    input  logic        wb_ld_unsigned,
    input  logic [31:0] wb_rdata,
    input  logic [31:0] wb_mm_addr,
    input  logic [1:0]  wb_mm_access_sz,
    input  logic [4:0]  wb_reg_d,
    input  logic        wb_reg_d_wen,
    input  logic        wb_csr_we,
    input  logic [13:0] wb_csr_addr,
    input  logic [31:0] wb_csr_wdata,
    input  logic [31:0] wb_csr_wmask,
    input  logic        wb_adef,
    input  logic        wb_sys,
    input  logic        wb_brk,
    input  logic        wb_ine,
    input  logic        wb_ale,
    input  logic        wb_interrupt,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_esubcode,
    input  logic        wb_ertn,
    input  logic        wb_flush_before,
    input  logic [31:0] csr_eentry,
    input  logic [31:0] csr_era,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        csr_we,
    output logic [13:0] csr_addr,
    output logic [31:0] csr_wdata,
    output logic [31:0] csr_wmask,
    output logic        ex_commit,
    output logic [5:0]  ex_ecode,
    output logic [8:0]  ex_esubcode,
    output logic [31:0] ex_era,
    output logic        ex_badv_we,
    output logic [31:0] ex_badv,
    output logic        ertn_commit,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        pipe_flush,
    output logic [31:0] debug_pc,
    output logic [3:0]  debug_rf_we,
    output logic [4:0]  debug_rf_wnum,
    output logic [31:0] debug_rf_wdata
);

    // state | meaning
    // RUN   | retiring instructions normally
    // DRAIN | redirect taken; pipe_flush held, incoming instructions discarded
    typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

    state_t      state_q;
    logic [3:0]  cnt_q;

    logic        live;
    logic        exc;
    logic        redirect;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] ld_data;
    logic [31:0] wdata_d;

    assign live     = wb_valid && (state_q == RUN);
    assign exc      = wb_adef | wb_sys | wb_brk | wb_ine | wb_ale | wb_interrupt;
    assign redirect = live && (exc || wb_ertn || wb_flush_before);

    always_comb begin
        byte_lane = 8'h00;
        case (wb_mm_addr[1:0])
            2'd0: byte_lane = wb_rdata[7:0];
            2'd1: byte_lane = wb_rdata[15:8];
            2'd2: byte_lane = wb_rdata[23:16];
            2'd3: byte_lane = wb_rdata[31:24];
            default: byte_lane = 8'h00;
        endcase
        half_lane = wb_mm_addr[1] ? wb_rdata[31:16] : wb_rdata[15:0];
        case (wb_mm_access_sz)
            2'd0:    ld_data = {{24{~wb_ld_unsigned & byte_lane[7]}}, byte_lane};
            2'd1:    ld_data = {{16{~wb_ld_unsigned & half_lane[15]}}, half_lane};
            default: ld_data = wb_rdata;
        endcase
        wdata_d = wb_is_load ? ld_data : wb_exe_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RUN;
            cnt_q          <= 4'd0;
            rf_we          <= 1'b0;
            rf_waddr       <= 5'd0;
            rf_wdata       <= 32'd0;
            csr_we         <= 1'b0;
            csr_addr       <= 14'd0;
            csr_wdata      <= 32'd0;
            csr_wmask      <= 32'd0;
            ex_commit      <= 1'b0;
            ex_ecode       <= 6'd0;
            ex_esubcode    <= 9'd0;
            ex_era         <= 32'd0;
            ex_badv_we     <= 1'b0;
            ex_badv        <= 32'd0;
            ertn_commit    <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
            pipe_flush     <= 1'b0;
            debug_pc       <= RESET_PC;
            debug_rf_we    <= 4'd0;
            debug_rf_wnum  <= 5'd0;
            debug_rf_wdata <= 32'd0;
        end else begin
            rf_we          <= 1'b0;
            csr_we         <= 1'b0;
            ex_commit      <= 1'b0;
            ex_badv_we     <= 1'b0;
            ertn_commit    <= 1'b0;
            redirect_valid <= 1'b0;
            debug_rf_we    <= 4'd0;

            case (state_q)
                RUN: begin
                    if (redirect) begin
                        state_q    <= DRAIN;
                        cnt_q      <= DRAIN_LAST;
                        pipe_flush <= 1'b1;
                    end else begin
                        pipe_flush <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (cnt_q == 4'd0) begin
                        state_q    <= RUN;
                        pipe_flush <= 1'b0;
                    end else begin
                        cnt_q      <= cnt_q - 4'd1;
                        pipe_flush <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= RUN;
                    pipe_flush <= 1'b0;
                end
            endcase

            // Exception outranks ERTN, which outranks a normal commit.
            if (live) begin
                if (exc) begin
                    ex_commit      <= 1'b1;
                    ex_ecode       <= wb_ecode;
                    ex_esubcode    <= wb_esubcode;
                    ex_era         <= wb_pc;
                    ex_badv_we     <= wb_adef | wb_ale;
                    ex_badv        <= wb_adef ? wb_pc : wb_mm_addr;
                    redirect_valid <= 1'b1;
                    redirect_pc    <= csr_eentry;
                end else if (wb_ertn) begin
                    ertn_commit    <= 1'b1;
                    redirect_valid <= 1'b1;
                    redirect_pc    <= csr_era;
                end else begin
                    rf_we          <= wb_reg_d_wen && (wb_reg_d != 5'd0);
                    rf_waddr       <= wb_reg_d;
                    rf_wdata       <= wdata_d;
                    csr_we         <= wb_csr_we;
                    csr_addr       <= wb_csr_addr;
                    csr_wdata      <= wb_csr_wdata;
                    csr_wmask      <= wb_csr_wmask;
                    debug_pc       <= wb_pc;
                    debug_rf_we    <= {4{wb_reg_d_wen && (wb_reg_d != 5'd0)}};
                    debug_rf_wnum  <= wb_reg_d;
                    debug_rf_wdata <= wdata_d;
                    if (wb_flush_before) begin
                        redirect_valid <= 1'b1;
                        redirect_pc    <= wb_pc + 32'd4;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_commit.sv
// Directed bench for wb_commit: table-driven load/ALU commits plus
// hand-written exception, ERTN, refetch and reset-during-drain sequences.
module tb_wb_commit;

    logic        clk, rst;
    logic        wb_valid;
    logic [31:0] wb_pc, wb_exe_out, wb_rdata, wb_mm_addr;
    logic        wb_is_load, wb_ld_unsigned;
    logic [1:0]  wb_mm_access_sz;
    logic [4:0]  wb_reg_d;
    logic        wb_reg_d_wen, wb_csr_we;
    logic [13:0] wb_csr_addr;
    logic [31:0] wb_csr_wdata, wb_csr_wmask;
    logic        wb_adef, wb_sys, wb_brk, wb_ine, wb_ale, wb_interrupt;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic        wb_ertn, wb_flush_before;
    logic [31:0] csr_eentry, csr_era;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        csr_we;
    logic [13:0] csr_addr;
    logic [31:0] csr_wdata, csr_wmask;
    logic        ex_commit;
    logic [5:0]  ex_ecode;
    logic [8:0]  ex_esubcode;
    logic [31:0] ex_era;
    logic        ex_badv_we;
    logic [31:0] ex_badv;
    logic        ertn_commit, redirect_valid;
    logic [31:0] redirect_pc;
    logic        pipe_flush;
    logic [31:0] debug_pc;
    logic [3:0]  debug_rf_we;
    logic [4:0]  debug_rf_wnum;
    logic [31:0] debug_rf_wdata;

    int total = 0;
    int bad   = 0;

    wb_commit #(.DRAIN_CYCLES(3), .RESET_PC(32'h1c000000)) dut (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_pc(wb_pc),
        .wb_exe_out(wb_exe_out), .wb_is_load(wb_is_load),
        .wb_ld_unsigned(wb_ld_unsigned), .wb_rdata(wb_rdata),
        .wb_mm_addr(wb_mm_addr), .wb_mm_access_sz(wb_mm_access_sz),
        .wb_reg_d(wb_reg_d), .wb_reg_d_wen(wb_reg_d_wen),
        .wb_csr_we(wb_csr_we), .wb_csr_addr(wb_csr_addr),
        .wb_csr_wdata(wb_csr_wdata), .wb_csr_wmask(wb_csr_wmask),
        .wb_adef(wb_adef), .wb_sys(wb_sys), .wb_brk(wb_brk), .wb_ine(wb_ine),
        .wb_ale(wb_ale), .wb_interrupt(wb_interrupt), .wb_ecode(wb_ecode),
        .wb_esubcode(wb_esubcode), .wb_ertn(wb_ertn),
        .wb_flush_before(wb_flush_before), .csr_eentry(csr_eentry),
        .csr_era(csr_era), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .csr_we(csr_we), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .csr_wmask(csr_wmask), .ex_commit(ex_commit),
        .ex_ecode(ex_ecode), .ex_esubcode(ex_esubcode), .ex_era(ex_era),
        .ex_badv_we(ex_badv_we), .ex_badv(ex_badv), .ertn_commit(ertn_commit),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .pipe_flush(pipe_flush), .debug_pc(debug_pc),
        .debug_rf_we(debug_rf_we), .debug_rf_wnum(debug_rf_wnum),
        .debug_rf_wdata(debug_rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_load;
        logic        uns;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [31:0] exe;
        logic [4:0]  rd;
        logic        wen;
        logic        exp_we;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        wb_valid = 0; wb_pc = 0; wb_exe_out = 0; wb_is_load = 0;
        wb_ld_unsigned = 0; wb_rdata = 0; wb_mm_addr = 0; wb_mm_access_sz = 0;
        wb_reg_d = 0; wb_reg_d_wen = 0; wb_csr_we = 0; wb_csr_addr = 0;
        wb_csr_wdata = 0; wb_csr_wmask = 0; wb_adef = 0; wb_sys = 0; wb_brk = 0;
        wb_ine = 0; wb_ale = 0; wb_interrupt = 0; wb_ecode = 0; wb_esubcode = 0;
        wb_ertn = 0; wb_flush_before = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_run();
        int n;
        n = 0;
        clear_inputs();
        while (pipe_flush && n < 20) begin
            step();
            n++;
        end
        check("drain_timeout", {31'd0, pipe_flush}, 32'd0);
    endtask

    initial begin
        int flushes;
        int side;

        vecs[0] = '{1'b1, 1'b0, 2'd0, 32'h00000003, 32'h80FF1234, 32'h0, 5'd5,  1'b1, 1'b1, 32'hFFFFFF80};
        vecs[1] = '{1'b1, 1'b1, 2'd0, 32'h00000003, 32'h80FF1234, 32'h0, 5'd5,  1'b1, 1'b1, 32'h00000080};
        vecs[2] = '{1'b1, 1'b1, 2'd1, 32'h00000002, 32'hBEEF0000, 32'h0, 5'd6,  1'b1, 1'b1, 32'h0000BEEF};
        vecs[3] = '{1'b1, 1'b0, 2'd1, 32'h00000000, 32'h12348001, 32'h0, 5'd7,  1'b1, 1'b1, 32'hFFFF8001};
        vecs[4] = '{1'b1, 1'b0, 2'd2, 32'h00000000, 32'hDEADBEEF, 32'h0, 5'd8,  1'b1, 1'b1, 32'hDEADBEEF};
        vecs[5] = '{1'b1, 1'b0, 2'd3, 32'h00000001, 32'h01234567, 32'h0, 5'd9,  1'b1, 1'b1, 32'h01234567};
        vecs[6] = '{1'b1, 1'b0, 2'd0, 32'h00000001, 32'h00007F00, 32'h0, 5'd10, 1'b1, 1'b1, 32'h0000007F};
        vecs[7] = '{1'b0, 1'b0, 2'd0, 32'h00000000, 32'hFFFFFFFF, 32'hCAFEF00D, 5'd31, 1'b1, 1'b1, 32'hCAFEF00D};
        vecs[8] = '{1'b1, 1'b1, 2'd1, 32'h00000002, 32'hBEEF0000, 32'h0, 5'd0,  1'b1, 1'b0, 32'h0};
        vecs[9] = '{1'b0, 1'b0, 2'd0, 32'h00000000, 32'h0, 32'h5555, 5'd7,  1'b0, 1'b0, 32'h0};

        clear_inputs();
        csr_eentry = 32'h1c008000;
        csr_era    = 32'h1c000100;
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_debug_pc", debug_pc, 32'h1c000000);
        check("reset_rf_we", {31'd0, rf_we}, 32'd0);
        check("reset_flush", {31'd0, pipe_flush}, 32'd0);
        check("reset_redirect_pc", redirect_pc, 32'd0);
        rst = 0;

        for (int i = 0; i < 10; i++) begin
            clear_inputs();
            wb_valid        = 1;
            wb_pc           = 32'h1c000100 + 32'(i * 4);
            wb_is_load      = vecs[i].is_load;
            wb_ld_unsigned  = vecs[i].uns;
            wb_mm_access_sz = vecs[i].sz;
            wb_mm_addr      = vecs[i].addr;
            wb_rdata        = vecs[i].rdata;
            wb_exe_out      = vecs[i].exe;
            wb_reg_d        = vecs[i].rd;
            wb_reg_d_wen    = vecs[i].wen;
            step();
            check($sformatf("v%0d_rf_we", i), {31'd0, rf_we}, {31'd0, vecs[i].exp_we});
            check($sformatf("v%0d_dbg_we", i), {28'd0, debug_rf_we}, {28'd0, {4{vecs[i].exp_we}}});
            check($sformatf("v%0d_dbg_pc", i), debug_pc, 32'h1c000100 + 32'(i * 4));
            check($sformatf("v%0d_redir", i), {31'd0, redirect_valid}, 32'd0);
            if (vecs[i].exp_we) begin
                check($sformatf("v%0d_waddr", i), {27'd0, rf_waddr}, {27'd0, vecs[i].rd});
                check($sformatf("v%0d_wdata", i), rf_wdata, vecs[i].exp_wdata);
                check($sformatf("v%0d_dbg_wdata", i), debug_rf_wdata, vecs[i].exp_wdata);
            end
        end

        clear_inputs();
        step();
        check("idle_rf_we", {31'd0, rf_we}, 32'd0);
        check("idle_debug_pc_hold", debug_pc, 32'h1c000124);
        check("idle_ex_commit", {31'd0, ex_commit}, 32'd0);

        // ALE: exception commit, then three drain cycles swallowing input
        clear_inputs();
        wb_valid = 1; wb_pc = 32'h1c000010; wb_mm_addr = 32'h1002; wb_ale = 1;
        wb_ecode = 6'h9; wb_reg_d = 5'd3; wb_reg_d_wen = 1; wb_csr_we = 1;
        step();
        check("ale_ex_commit", {31'd0, ex_commit}, 32'd1);
        check("ale_ecode", {26'd0, ex_ecode}, 32'h9);
        check("ale_badv_we", {31'd0, ex_badv_we}, 32'd1);
        check("ale_badv", ex_badv, 32'h1002);
        check("ale_era", ex_era, 32'h1c000010);
        check("ale_redirect_pc", redirect_pc, 32'h1c008000);
        check("ale_redirect_valid", {31'd0, redirect_valid}, 32'd1);
        check("ale_rf_we", {31'd0, rf_we}, 32'd0);
        check("ale_csr_we", {31'd0, csr_we}, 32'd0);
        flushes = pipe_flush ? 1 : 0;
        side = 0;
        clear_inputs();
        wb_valid = 1; wb_pc = 32'h1c000040; wb_exe_out = 32'h77;
        wb_reg_d = 5'd4; wb_reg_d_wen = 1; wb_csr_we = 1;
        for (int c = 0; c < 3; c++) begin
            step();
            if (pipe_flush) flushes++;
            if (rf_we || csr_we || ex_commit || redirect_valid) side++;
        end
        check("ale_flush_cycles", 32'(flushes), 32'd3);
        check("drain_side_effects", 32'(side), 32'd0);
        step();
        check("post_drain_rf_we", {31'd0, rf_we}, 32'd1);
        check("post_drain_csr_we", {31'd0, csr_we}, 32'd1);
        check("post_drain_wdata", rf_wdata, 32'h77);
        clear_inputs();
        step();

        // ERTN
        clear_inputs();
        wb_valid = 1; wb_pc = 32'h1c000300; wb_ertn = 1; wb_reg_d = 5'd2; wb_reg_d_wen = 1;
        step();
        check("ertn_commit", {31'd0, ertn_commit}, 32'd1);
        check("ertn_redirect_pc", redirect_pc, 32'h1c000100);
        check("ertn_ex_commit", {31'd0, ex_commit}, 32'd0);
        check("ertn_rf_we", {31'd0, rf_we}, 32'd0);
        check("ertn_flush", {31'd0, pipe_flush}, 32'd1);
        wait_run();

        // ERTN together with SYS: exception wins
        clear_inputs();
        wb_valid = 1; wb_pc = 32'h1c000304; wb_ertn = 1; wb_sys = 1; wb_ecode = 6'hB;
        step();
        check("sysertn_ex_commit", {31'd0, ex_commit}, 32'd1);
        check("sysertn_ertn", {31'd0, ertn_commit}, 32'd0);
        check("sysertn_redirect_pc", redirect_pc, 32'h1c008000);
        check("sysertn_badv_we", {31'd0, ex_badv_we}, 32'd0);
        check("sysertn_ecode", {26'd0, ex_ecode}, 32'hB);
        wait_run();

        // CSR write with refetch at the top of the address space
        clear_inputs();
        wb_valid = 1; wb_pc = 32'hFFFFFFFC; wb_csr_we = 1; wb_csr_addr = 14'h0006;
        wb_csr_wdata = 32'hA5A5A5A5; wb_csr_wmask = 32'h0000FFFF; wb_flush_before = 1;
        wb_exe_out = 32'h11; wb_reg_d = 5'd6; wb_reg_d_wen = 1;
        step();
        check("refetch_csr_we", {31'd0, csr_we}, 32'd1);
        check("refetch_csr_addr", {18'd0, csr_addr}, 32'h6);
        check("refetch_csr_wdata", csr_wdata, 32'hA5A5A5A5);
        check("refetch_csr_wmask", csr_wmask, 32'h0000FFFF);
        check("refetch_redirect_pc", redirect_pc, 32'h00000000);
        check("refetch_redirect_valid", {31'd0, redirect_valid}, 32'd1);
        check("refetch_flush", {31'd0, pipe_flush}, 32'd1);
        check("refetch_rf_we", {31'd0, rf_we}, 32'd1);
        check("refetch_debug_pc", debug_pc, 32'hFFFFFFFC);
        wait_run();

        // ADEF, then reset in the second drain cycle
        clear_inputs();
        wb_valid = 1; wb_pc = 32'h1c000023; wb_adef = 1; wb_mm_addr = 32'h4444;
        step();
        check("adef_badv", ex_badv, 32'h1c000023);
        check("adef_badv_we", {31'd0, ex_badv_we}, 32'd1);
        clear_inputs();
        step();
        check("adef_drain2_flush", {31'd0, pipe_flush}, 32'd1);
        rst = 1;
        step();
        check("rst_drain_flush", {31'd0, pipe_flush}, 32'd0);
        check("rst_drain_debug_pc", debug_pc, 32'h1c000000);
        rst = 0;
        wb_valid = 1; wb_pc = 32'h1c000200; wb_exe_out = 32'h1234;
        wb_reg_d = 5'd9; wb_reg_d_wen = 1;
        step();
        check("after_rst_rf_we", {31'd0, rf_we}, 32'd1);
        check("after_rst_wdata", rf_wdata, 32'h1234);
        check("after_rst_debug_pc", debug_pc, 32'h1c000200);
        clear_inputs();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
